// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial deserialiser slice.
//   state_t    : receiver FSM states (IDLE waits for Start, RECV collects bits)
//   FRAME_BITS : number of serial bits assembled into one output word
//   CNT_W      : width of the bit counter (indexes 0..FRAME_BITS-1)
// ---------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int FRAME_BITS = 8;
    localparam int CNT_W      = 3;

endpackage

// File: rtl/rx_shift_cnt.sv
// ---------------------------------------------------------------------------
// rx_shift_cnt
// Serial-in shift register plus bit counter for one frame. Bits enter at the
// MSB and move toward the LSB, so after FRAME_BITS shifts the first bit sent
// sits in bit 0 (LSB-first framing).
// Ports:
//   i_clk     : rising-edge clock
//   i_clear   : synchronous active-high reset (counter and register to 0)
//   i_restart : start of a new frame, counter back to 0 (wins over i_shift)
//   i_shift   : accept i_bit this cycle
//   i_bit     : serial data bit
//   o_sr      : current shift register contents
//   o_last    : the next accepted bit completes the frame
// ---------------------------------------------------------------------------
module rx_shift_cnt
    import serial_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_clear,
    input  logic                  i_restart,
    input  logic                  i_shift,
    input  logic                  i_bit,
    output logic [FRAME_BITS-1:0] o_sr,
    output logic                  o_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    logic [CNT_W-1:0]      r_cnt;
    logic [FRAME_BITS-1:0] r_sr;

    // Counter and data register. A restart only rewinds the counter; the stale
    // register contents are harmless because a full frame overwrites every bit
    // before a word is taken from it. The counter wraps to 0 on its own after
    // the last bit, ready for the next frame.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_cnt <= '0;
            r_sr  <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_shift) begin
            r_cnt <= r_cnt + 1'b1;
            r_sr  <= {i_bit, r_sr[FRAME_BITS-1:1]};
        end
    end

    assign o_sr   = r_sr;
    assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/serial_deser_8.sv
// ---------------------------------------------------------------------------
// serial_deser_8
// Receives LSB-first serial frames of FRAME_BITS bits and presents each
// completed word through a valid/ready style output register.
// Ports:
//   Clk        : rising-edge clock
//   Clear      : synchronous active-high reset
//   Start      : arm (or re-arm) reception of a new frame
//   Shift_En   : Shift_In is valid this cycle
//   Shift_In   : serial data bit, LSB first
//   Rd_Ready   : consumer takes Data_Out on this edge when Data_Valid is set
//   Data_Out   : last assembled word
//   Data_Valid : Data_Out holds an unread word
//   Busy       : a frame is being received
//   Overrun    : sticky, a completed word was dropped because Data_Out was full
// ---------------------------------------------------------------------------
module serial_deser_8 #(
    parameter int FRAME_BITS = 8
) (
    input  logic                  Clk,
    input  logic                  Clear,
    input  logic                  Start,
    input  logic                  Shift_En,
    input  logic                  Shift_In,
    input  logic                  Rd_Ready,
    output logic [FRAME_BITS-1:0] Data_Out,
    output logic                  Data_Valid,
    output logic                  Busy,
    output logic                  Overrun
);

    import serial_pkg::*;

    state_t                r_state;
    state_t                w_stateNext;
    logic                  w_shift;
    logic                  w_complete;
    logic                  w_last;
    logic                  w_consume;
    logic [FRAME_BITS-1:0] w_sr;
    logic [FRAME_BITS-1:0] w_newByte;
    logic [FRAME_BITS-1:0] r_dataOut;
    logic                  r_dataValid;
    logic                  r_overrun;

    rx_shift_cnt u_rxShiftCnt (
        .i_clk     (Clk),
        .i_clear   (Clear),
        .i_restart (Start),
        .i_shift   (w_shift),
        .i_bit     (Shift_In),
        .o_sr      (w_sr),
        .o_last    (w_last)
    );

    // The completed word includes the bit arriving on this very edge, so it is
    // formed combinationally and registered straight into Data_Out.
    assign w_newByte = {Shift_In, w_sr[FRAME_BITS-1:1]};
    assign w_consume = r_dataValid & Rd_Ready;

    // State register.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and shift qualification. Start always wins: it rewinds the
    // frame (handled in the sub-module) and suppresses any shift on that edge,
    // including one that would otherwise have completed the frame.
    always_comb begin
        w_stateNext = r_state;
        w_shift     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_stateNext = RECV;
                end
            end
            RECV: begin
                if (!Start && Shift_En) begin
                    w_shift = 1'b1;
                    if (w_last) begin
                        w_complete  = 1'b1;
                        w_stateNext = IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Output register and handshake. A completing word is accepted when the
    // register is empty or being drained on the same edge; otherwise it is
    // dropped, the held word is left untouched and Overrun latches until Clear.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_complete) begin
            if (!r_dataValid || w_consume) begin
                r_dataOut   <= w_newByte;
                r_dataValid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (w_consume) begin
            r_dataValid <= 1'b0;
        end
    end

    assign Data_Out   = r_dataOut;
    assign Data_Valid = r_dataValid;
    assign Overrun    = r_overrun;
    assign Busy       = (r_state == RECV);

endmodule

// File: tb/tb_serial_deser_8.sv
// ---------------------------------------------------------------------------
// tb_serial_deser_8
// Directed scenarios followed by random traffic. A frame-level reference
// model (bit index + arithmetic accumulation) predicts every output each
// cycle; the directed scenarios also check fixed expected words.
// ---------------------------------------------------------------------------
module tb_serial_deser_8;

    logic       Clk;
    logic       Clear;
    logic       Start;
    logic       Shift_En;
    logic       Shift_In;
    logic       Rd_Ready;
    logic [7:0] Data_Out;
    logic       Data_Valid;
    logic       Busy;
    logic       Overrun;

    int totalChecks;
    int badChecks;

    bit         mBusy;
    int         mCount;
    int         mAcc;
    logic [7:0] mOut;
    bit         mValid;
    bit         mOverrun;

    serial_deser_8 #(.FRAME_BITS(8)) dut (
        .Clk        (Clk),
        .Clear      (Clear),
        .Start      (Start),
        .Shift_En   (Shift_En),
        .Shift_In   (Shift_In),
        .Rd_Ready   (Rd_Ready),
        .Data_Out   (Data_Out),
        .Data_Valid (Data_Valid),
        .Busy       (Busy),
        .Overrun    (Overrun)
    );

    // Free-running clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Frame-level reference: a frame is "collecting" while busy, bit k of the
    // word is the k-th accepted bit, and a finished word goes to the output
    // slot only if the slot is empty or drained on the same edge.
    task automatic modelStep(input bit st, input bit en, input bit b,
                             input bit rdy, input bit clr);
        bit         done;
        logic [7:0] word;
        bit         drained;
        done = 1'b0;
        word = 8'h00;
        if (clr) begin
            mBusy = 0; mCount = 0; mAcc = 0;
            mOut = 8'h00; mValid = 0; mOverrun = 0;
        end else begin
            if (st) begin
                mBusy = 1; mCount = 0; mAcc = 0;
            end else if (mBusy && en) begin
                mAcc = mAcc | (int'(b) << mCount);
                mCount = mCount + 1;
                if (mCount == 8) begin
                    done = 1'b1;
                    word = mAcc[7:0];
                    mBusy = 0; mCount = 0; mAcc = 0;
                end
            end
            drained = mValid && rdy;
            if (done) begin
                if (!mValid || drained) begin
                    mOut = word;
                    mValid = 1;
                end else begin
                    mOverrun = 1;
                end
            end else if (drained) begin
                mValid = 0;
            end
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, then
    // compare all outputs shortly after the edge.
    task automatic applyStimulus(input bit st, input bit en, input bit b,
                                 input bit rdy, input bit clr);
        Start    = st;
        Shift_En = en;
        Shift_In = b;
        Rd_Ready = rdy;
        Clear    = clr;
        @(posedge Clk);
        modelStep(st, en, b, rdy, clr);
        #1;
        checkOutput("dout",    Data_Out,   mOut);
        checkOutput("valid",   Data_Valid, mValid);
        checkOutput("busy",    Busy,       mBusy);
        checkOutput("overrun", Overrun,    mOverrun);
    endtask

    // Sends nbits of a word LSB first with random idle gaps of 0..maxGap
    // cycles before each bit; Rd_Ready is only raised on the final bit edge.
    task automatic sendBits(input logic [7:0] w, input int nbits, input int maxGap,
                            input bit rdyLast);
        for (int i = 0; i < nbits; i++) begin
            int gap;
            gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
                checkOutput("gapBusy", Busy, 1'b1);
            end
            applyStimulus(1'b0, 1'b1, w[i], (i == nbits - 1) ? rdyLast : 1'b0, 1'b0);
            if (i != nbits - 1) checkOutput("frameBusy", Busy, 1'b1);
        end
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        Start = 0; Shift_En = 0; Shift_In = 0; Rd_Ready = 0; Clear = 1;

        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 1, 1);
        checkOutput("rstDout",  Data_Out,   8'h00);
        checkOutput("rstValid", Data_Valid, 1'b0);
        checkOutput("rstBusy",  Busy,       1'b0);
        checkOutput("rstOvr",   Overrun,    1'b0);

        $display("[TB] basic byte A5");
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("startBusy", Busy, 1'b1);
        sendBits(8'hA5, 8, 0, 0);
        checkOutput("basicDout",  Data_Out,   8'hA5);
        checkOutput("basicValid", Data_Valid, 1'b1);
        checkOutput("basicBusy",  Busy,       1'b0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("basicDrain", Data_Valid, 1'b0);

        $display("[TB] gapped byte 3C");
        applyStimulus(1, 0, 0, 0, 0);
        sendBits(8'h3C, 8, 3, 0);
        checkOutput("gapDout", Data_Out, 8'h3C);
        applyStimulus(0, 0, 0, 1, 0);

        $display("[TB] overrun");
        applyStimulus(1, 0, 0, 0, 0);
        sendBits(8'h11, 8, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        sendBits(8'h22, 8, 1, 0);
        checkOutput("ovrDout", Data_Out, 8'h11);
        checkOutput("ovrFlag", Overrun,  1'b1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("ovrDrain",  Data_Valid, 1'b0);
        checkOutput("ovrSticky", Overrun,    1'b1);
        applyStimulus(0, 0, 0, 0, 1);

        $display("[TB] simultaneous consume");
        applyStimulus(1, 0, 0, 0, 0);
        sendBits(8'h11, 8, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        sendBits(8'h22, 8, 2, 1);
        checkOutput("simDout",  Data_Out,   8'h22);
        checkOutput("simValid", Data_Valid, 1'b1);
        checkOutput("simOvr",   Overrun,    1'b0);
        applyStimulus(0, 0, 0, 1, 0);

        $display("[TB] restart mid-frame");
        applyStimulus(1, 0, 0, 0, 0);
        sendBits(8'hFF, 5, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        sendBits(8'h0F, 8, 0, 0);
        checkOutput("restartDout", Data_Out, 8'h0F);
        applyStimulus(0, 0, 0, 1, 0);

        $display("[TB] start on completion edge");
        applyStimulus(1, 0, 0, 0, 0);
        sendBits(8'hC3, 7, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("prioValid", Data_Valid, 1'b0);
        checkOutput("prioBusy",  Busy,       1'b1);
        sendBits(8'h96, 8, 0, 0);
        checkOutput("prioDout", Data_Out, 8'h96);
        applyStimulus(0, 0, 0, 1, 0);

        $display("[TB] clear mid-frame");
        applyStimulus(1, 0, 0, 0, 0);
        sendBits(8'hFF, 4, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("clrDout",  Data_Out,   8'h00);
        checkOutput("clrValid", Data_Valid, 1'b0);
        checkOutput("clrBusy",  Busy,       1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 0);
        checkOutput("clrNoRecv", Data_Valid, 1'b0);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(19, 0) == 0), 1'($urandom), 1'($urandom),
                          ($urandom_range(2, 0) == 0), ($urandom_range(299, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/serial_deser_8.md
SERIAL_DESER_8 -- requirements
Module: serial_deser_8

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: Clk is the only clock, and Clear is the reset.
REQ-002 Parameters:
- FRAME_BITS, default 8, bits per frame (fixed at 8; other values are not supported).
REQ-003 Ports (name, direction, width, meaning):
- Clk, in, 1, rising-edge clock.
- Clear, in, 1, synchronous active-high reset.
- Start, in, 1, arms or re-arms reception of a new frame.
- Shift_En, in, 1, qualifies Shift_In as valid this cycle.
- Shift_In, in, 1, serial data bit, LSB first.
- Rd_Ready, in, 1, consumer accepts Data_Out.
- Data_Out, out, 8, assembled byte.
- Data_Valid, out, 1, Data_Out holds an unread byte.
- Busy, out, 1, a frame is in progress.
- Overrun, out, 1, sticky flag: a completed byte was dropped.

Function
REQ-004 The FSM SHALL have exactly two states: IDLE and RECV. Busy SHALL be 1 exactly when the state is RECV.
REQ-005 In IDLE, Start=1 SHALL move the FSM to RECV and clear the bit counter to 0; Shift_En in that same cycle SHALL be ignored.
REQ-006 In IDLE without Start, Shift_En/Shift_In SHALL be ignored and the internal shift register SHALL hold.
REQ-007 In RECV, each cycle with Shift_En=1 SHALL update the shift register to {Shift_In, sr[7:1]} and increment the 3-bit counter.
REQ-008 In RECV, a cycle with Shift_En=0 SHALL hold the counter and the shift register; gaps of any length are legal.
REQ-009 The edge that samples the 8th bit (counter=7 and Shift_En=1) SHALL return the FSM to IDLE and produce the byte {Shift_In, sr[7:1]}.
REQ-010 A produced byte SHALL appear on Data_Out with Data_Valid=1 immediately after that same edge, i.e. zero extra cycles of latency.
REQ-011 The handshake SHALL work as follows:
- Data_Valid stays 1, and Data_Out stays stable, until an edge where Data_Valid=1 and Rd_Ready=1.
- At that edge Data_Valid clears, unless REQ-012 applies.
- Rd_Ready has no effect while Data_Valid=0.
REQ-012 If a byte completes on the same edge that consumes the current byte, the new byte SHALL load into Data_Out and Data_Valid SHALL remain 1.
REQ-013 If a byte completes while Data_Valid=1 and the current byte is not consumed on that edge:
- the new byte is discarded;
- Data_Out is unchanged;
- Overrun is set to 1 and stays set until Clear.
REQ-014 Start=1 in RECV SHALL discard the partial frame, reset the counter to 0 and remain in RECV; Shift_En in that cycle SHALL be ignored.
REQ-015 Start=1 on the completion edge SHALL take priority: the completing bit is discarded, no byte is produced, and the FSM stays in RECV with the counter at 0.
REQ-016 Start and reception SHALL NOT affect Data_Out, Data_Valid or Overrun, except through byte completion.

Reset
REQ-017 Clear=1 at a rising edge SHALL apply the following values, overriding all other inputs:
- state = IDLE, counter = 0, shift register = 8'h00;
- Data_Out = 8'h00, Data_Valid = 0, Busy = 0, Overrun = 0.
REQ-018 Clear asserted mid-frame or while Data_Valid=1 SHALL discard all pending data; reception SHALL resume only after a new Start.

Structure
REQ-019 A shared package serial_pkg SHALL hold:
- the state enum (IDLE, RECV);
- FRAME_BITS = 8;
- the counter-width constant (3).
REQ-020 The shift register with its bit counter SHALL be one sub-module, rx_shift_cnt. The FSM, output register and handshake logic SHALL stay in serial_deser_8.
REQ-021 All state SHALL be held in always_ff on posedge Clk. There SHALL be no latches and no asynchronous reset.

Verification
REQ-022 Basic byte: Start, then 8 back-to-back Shift_En bits 1,0,1,0,0,1,0,1 -> after the 8th edge, Data_Out=8'hA5, Data_Valid=1, Busy=0.
REQ-023 Gapped input: bits for 8'h3C with 0-3 idle cycles between bits -> Data_Out=8'h3C; Busy=1 throughout the frame.
REQ-024 Overrun: receive 8'h11 and hold Rd_Ready=0, then receive 8'h22 -> Data_Out=8'h11, Overrun=1; then Rd_Ready=1 for one edge -> Data_Valid=0, Overrun stays 1.
REQ-025 Simultaneous consume: with 8'h11 valid, assert Rd_Ready on the edge that completes 8'h22 -> Data_Out=8'h22, Data_Valid=1, Overrun=0.
REQ-026 Restart: 5 bits of 8'hFF, then Start, then 8 bits of 8'h0F -> Data_Out=8'h0F.
REQ-027 Reset: Clear after 4 bits -> all outputs at reset values; 4 more Shift_En bits without Start -> Data_Valid stays 0.
